fc_argmax_sink: RTL
===================

Name: fc_argmax_sink

Overview:
- Receiving end of the fc layer's serial output stream.
- Consumes W_M signed results per inference over the same valid/ready handshake that fc blocks use on their output port.
- Tracks the running maximum and its position, then presents one {index, value} classification result downstream with its own valid/ready handshake.
- Collection of the next vector overlaps with a pending, unconsumed result.

Parameters:
- WIDTH, 16, bit width of each signed data element (matches fc WIDTH).
- W_M, 4, number of elements per vector (fc output count); legal range 1 and up.
- IDXW, derived localparam = max(1, $clog2(W_M)), width of the index output.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- input_valid  in  1  upstream element valid (driven by fc output_valid).
- input_ready  out  1  sink can accept an element this cycle.
- input_data  in  WIDTH  signed element (fc output_data).
- output_valid  out  1  classification result available.
- output_ready  in  1  downstream accepts the result this cycle.
- output_index  out  IDXW  position (0..W_M-1) of the maximum element.
- output_data  out  WIDTH  signed maximum value.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: output_valid=0, output_index=0, output_data=0. Element counter cnt=0; running max_val=0, max_idx=0.
- input_ready is forced 0 in any cycle where reset=1.
- Accept: an element transfers when input_valid && input_ready at a rising edge. Each accept increments cnt.
- Running-max update on accept:
  - if cnt==0, or input_data > max_val (signed, strict), load max_val=input_data and max_idx=cnt.
  - Ties keep the lowest index.
- Vector completion: the accept with cnt==W_M-1 completes the vector.
  - Final {idx, val} includes that element's comparison.
  - Result loads into the output register; output_valid=1 from the next cycle (latency 1 cycle after the last accept).
  - cnt wraps to 0; running max state is don't-care and is reloaded by the next cnt==0 accept.
- input_ready = !(cnt==W_M-1 && output_valid).
  - Registered terms only; no combinational path from output_ready to input_ready.
  - Consequence: if the result register is occupied, the final element of the next vector stalls, even in a cycle where output_ready=1. It is accepted no earlier than the cycle after the pending result is consumed.
- Elements 0..W_M-2 of the next vector are always accepted while a result is pending.
- Output handshake: the result transfers when output_valid && output_ready; output_valid clears the next cycle.
  - While output_valid && !output_ready, output_index and output_data stay stable.
  - Consume and a new completion cannot fall in the same cycle, because the stall rule forbids it.
- W_M=1: every accepted element is a result with index 0; input_ready=!output_valid.
- Throughput: with output_ready held 1, one element per cycle sustained, no bubbles between vectors. output_valid pulses for 1 cycle per vector.
- Reset mid-vector or with a result pending: the partial vector and pending result are discarded; the next accept is element 0 of a fresh vector.
- input_data is ignored when input_valid=0. The sink never drops or duplicates an accepted element.

Decomposition:
- Shared package fc_stream_pkg:
  - function idx_width(n) returning max(1, $clog2(n));
  - signed MAX/MIN constants for WIDTH=16 (32767, -32768), shared with mac.
- One sub-module is natural: fc_argmax_sink_tracker.
  - Holds cnt, max_val and max_idx, and the compare/load logic.
  - Reports last_accept.
- Top level holds the result register, output_valid and the input_ready logic.

Test Plan (W_M=4, WIDTH=16):
- Basic: stream 5,-3,9,2 back-to-back, output_ready=1 -> output_valid high exactly 1 cycle after the 4th accept, index=2, data=9, valid for 1 cycle.
- Ties/negatives:
  - 7,7,1,7 -> index=0, data=7.
  - -32768,-5,-100,-32768 -> index=1, data=-5.
- Backpressure: output_ready=0, send A=1,2,3,4 then B=4,3,2,1.
  - A result held at index=3, data=4 and stable.
  - B elements 0-2 accepted; input_ready=0 with B element 3 presented.
  - Raise output_ready 1 cycle -> A consumed; B element 3 accepted the following cycle -> result index=0, data=4.
- Reset mid-vector: accept 10,20, assert reset 1 cycle -> outputs 0, input_ready=0 during reset. Then 1,8,3,2 -> index=1, data=8.
- Reset with pending result: result pending, output_ready=0, assert reset -> output_valid=0 next cycle; the result is never delivered.
- Throughput: input_valid=1 continuously for 12 elements, output_ready=1 -> input_ready never low, 3 results, each output_valid pulse 1 cycle after its vector's last accept.

Source files
------------

// File: rtl/fc_stream_pkg.sv
// +----------------------------------------------------------------------+
// | fc_stream_pkg: shared helpers and saturation constants for fc stream |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fc_stream_pkg;

  localparam logic signed [15:0] C_FC_MAX = 16'sh7FFF;
  localparam logic signed [15:0] C_FC_MIN = 16'sh8000;

  // Index width never collapses to zero, even for single-element vectors.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fc_argmax_sink_tracker.sv
// +----------------------------------------------------------------------+
// | fc_argmax_sink_tracker: element counter and running arg-max state    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fc_argmax_sink_tracker
  import fc_stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int W_M   = 4,
  parameter int IDXW  = idx_width(W_M)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    accept,
  input  logic signed [WIDTH-1:0] data,
  output logic                    at_last,
  output logic                    last_accept,
  output logic [IDXW-1:0]         res_idx,
  output logic signed [WIDTH-1:0] res_val
);

  localparam logic [IDXW-1:0] C_LAST_CNT = IDXW'(W_M - 1);

  logic [IDXW-1:0]         r_cnt;
  logic signed [WIDTH-1:0] r_max_val;
  logic [IDXW-1:0]         r_max_idx;
  logic                    w_take;

  // First element of a vector always loads; later ones only on a strict win.
  assign w_take      = (r_cnt == '0) || (data > r_max_val);
  assign at_last     = (r_cnt == C_LAST_CNT);
  assign last_accept = accept && at_last;
  assign res_idx     = w_take ? r_cnt : r_max_idx;
  assign res_val     = w_take ? data  : r_max_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_max_val <= '0;
      r_max_idx <= '0;
    end else if (accept) begin
      r_max_val <= res_val;
      r_max_idx <= res_idx;
      r_cnt     <= at_last ? '0 : r_cnt + IDXW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fc_argmax_sink.sv
// +----------------------------------------------------------------------+
// | fc_argmax_sink: collects W_M signed fc outputs, emits {index, max}   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fc_argmax_sink
  import fc_stream_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int W_M   = 4,
  localparam int IDXW  = idx_width(W_M)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic signed [WIDTH-1:0] input_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [IDXW-1:0]         output_index,
  output logic signed [WIDTH-1:0] output_data
);

  logic                    w_accept;
  logic                    w_at_last;
  logic                    w_last_accept;
  logic [IDXW-1:0]         w_res_idx;
  logic signed [WIDTH-1:0] w_res_val;

  // Only registered terms here: the final element waits for the slot to be
  // empty, so a consume and a new completion never share a cycle.
  assign input_ready = !reset && !(w_at_last && output_valid);
  assign w_accept    = input_valid && input_ready;

  fc_argmax_sink_tracker #(
    .WIDTH (WIDTH),
    .W_M   (W_M),
    .IDXW  (IDXW)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .accept      (w_accept),
    .data        (input_data),
    .at_last     (w_at_last),
    .last_accept (w_last_accept),
    .res_idx     (w_res_idx),
    .res_val     (w_res_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      output_valid <= 1'b0;
      output_index <= '0;
      output_data  <= '0;
    end else if (w_last_accept) begin
      output_valid <= 1'b1;
      output_index <= w_res_idx;
      output_data  <= w_res_val;
    end else if (output_valid && output_ready) begin
      output_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
